regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32 pipeline, and the successor to the single-write, two-read file. It provides NR synchronous read ports with per-port read enable (stall hold) and NW write ports with fixed priority arbitration. Same-cycle write-to-read forwarding is done internally. Register 0 is hard-wired to zero. It sits between decode (read) and writeback (write), and supports dual-issue or extra operand ports.

---
 rtl/rv_pkg.sv | 8 +
 rtl/regfile_mp_fwd_sel.sv | 25 ++
 rtl/regfile_mp.sv | 78 +++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 register-file types and defaults.
package rv_pkg;
    localparam int XLEN_DEF = 32;
    localparam int REG_DEPTH_DEF = 32;
    typedef logic [4:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0] word_t;
    localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_mp_fwd_sel.sv
// rf_fwd_sel: priority select of the highest-index enabled write port hitting addr.
module rf_fwd_sel
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW = 5,
    parameter int NW = 1
) (
    input  logic [AW-1:0]      addr,
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   waddr,
    input  logic [NW*XLEN-1:0] wdata,
    output logic               hit,
    output logic [XLEN-1:0]    data
);
    always_comb begin
        hit = 1'b0;
        data = '0;
        for (int j = 0; j < NW; j++)
            if (we[j] && waddr[j*AW +: AW] == addr && addr != AW'(REG_ZERO)) begin
                hit = 1'b1;
                data = wdata[j*XLEN +: XLEN];
            end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with registered reads,
// priority writes, same-cycle forwarding and write-collision flag.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int DEPTH = REG_DEPTH_DEF,
    parameter int NR = 2,
    parameter int NW = 1,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NR-1:0]      ren_i,
    input  logic [NR*AW-1:0]   rsNum_i,
    output logic [NR*XLEN-1:0] rsVal_o,
    input  logic [NW-1:0]      regWrite_i,
    input  logic [NW*AW-1:0]   rdNum_i,
    input  logic [NW*XLEN-1:0] rdVal_i,
    output logic               wrConflict_o
);
    logic [XLEN-1:0] rf [1:DEPTH-1];
    logic [DEPTH-1:1] wr_hit;
    logic [XLEN-1:0] wr_data [1:DEPTH-1];
    logic [NR-1:0] rd_hit;
    logic [XLEN-1:0] rd_fwd [NR];
    logic [XLEN-1:0] rd_data [NR];
    logic conflict;

    genvar r, i;
    // One selector per storage register resolves write priority for that address.
    for (r = 1; r < DEPTH; r++) begin : g_wr
        rf_fwd_sel #(.XLEN(XLEN), .AW(AW), .NW(NW)) u_sel (
            .addr(AW'(r)), .we(regWrite_i), .waddr(rdNum_i), .wdata(rdVal_i),
            .hit(wr_hit[r]), .data(wr_data[r])
        );
    end

    for (i = 0; i < NR; i++) begin : g_rd
        rf_fwd_sel #(.XLEN(XLEN), .AW(AW), .NW(NW)) u_sel (
            .addr(rsNum_i[i*AW +: AW]), .we(regWrite_i), .waddr(rdNum_i), .wdata(rdVal_i),
            .hit(rd_hit[i]), .data(rd_fwd[i])
        );
    end

    always_comb begin
        for (int p = 0; p < NR; p++)
            rd_data[p] = rsNum_i[p*AW +: AW] == '0 ? '0 :
                         rd_hit[p] ? rd_fwd[p] : rf[rsNum_i[p*AW +: AW]];
    end

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < NW; j++)
            for (int k = j + 1; k < NW; k++)
                if (regWrite_i[j] && regWrite_i[k] && rdNum_i[j*AW +: AW] == rdNum_i[k*AW +: AW]
                    && rdNum_i[j*AW +: AW] != '0)
                    conflict = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < DEPTH; k++) rf[k] <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) if (wr_hit[k]) rf[k] <= wr_data[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsVal_o <= '0;
            wrConflict_o <= 1'b0;
        end else begin
            wrConflict_o <= conflict;
            for (int p = 0; p < NR; p++) if (ren_i[p]) rsVal_o[p*XLEN +: XLEN] <= rd_data[p];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against a behavioural model.
module tb_regfile_mp;
    localparam int XLEN = 32, DEPTH = 16, NR = 4, NW = 2, AW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] ren;
    logic [NR*AW-1:0] rs_num;
    logic [NR*XLEN-1:0] rs_val;
    logic [NW-1:0] reg_write;
    logic [NW*AW-1:0] rd_num;
    logic [NW*XLEN-1:0] rd_val;
    logic wr_conflict;

    int errors = 0;
    int checks = 0;
    logic started = 1'b0;

    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
        .clk(clk), .rst(rst), .ren_i(ren), .rsNum_i(rs_num), .rsVal_o(rs_val),
        .regWrite_i(reg_write), .rdNum_i(rd_num), .rdVal_i(rd_val), .wrConflict_o(wr_conflict)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural state, lane contents, collision flag.
    logic [XLEN-1:0] m_rf [DEPTH];
    logic [XLEN-1:0] m_lane [NR];
    logic m_conf;
    logic [XLEN-1:0] n_rf [DEPTH];
    bit written [DEPTH];
    int a;
    logic [XLEN-1:0] v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_rf[k] = '0;
            for (int k = 0; k < NR; k++) m_lane[k] = '0;
            m_conf = 1'b0;
        end else begin
            for (int p = 0; p < NR; p++) if (ren[p]) begin
                a = int'(rs_num[p*AW +: AW]);
                v = m_rf[a];
                if (a != 0)
                    for (int j = 0; j < NW; j++)
                        if (reg_write[j] && int'(rd_num[j*AW +: AW]) == a) v = rd_val[j*XLEN +: XLEN];
                m_lane[p] = v;
            end
            n_rf = m_rf;
            for (int k = 0; k < DEPTH; k++) written[k] = 1'b0;
            m_conf = 1'b0;
            for (int j = 0; j < NW; j++) if (reg_write[j]) begin
                a = int'(rd_num[j*AW +: AW]);
                if (a != 0) begin
                    if (written[a]) m_conf = 1'b1;
                    written[a] = 1'b1;
                    n_rf[a] = rd_val[j*XLEN +: XLEN];
                end
            end
            m_rf = n_rf;
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] lane(input int p);
        return rs_val[p*XLEN +: XLEN];
    endfunction

    always @(negedge clk) begin
        if (started && !rst) begin
            for (int p = 0; p < NR; p++) chk($sformatf("model_lane%0d", p), lane(p), m_lane[p]);
            chk("model_conflict", {31'b0, wr_conflict}, {31'b0, m_conf});
        end
    end

    task automatic idle();
        ren = '0; rs_num = '0; reg_write = '0; rd_num = '0; rd_val = '0;
    endtask

    task automatic wr(input int p, input int ad, input logic [XLEN-1:0] d);
        reg_write[p] = 1'b1;
        rd_num[p*AW +: AW] = AW'(ad);
        rd_val[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int p, input int ad);
        ren[p] = 1'b1;
        rs_num[p*AW +: AW] = AW'(ad);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        started = 1'b1;
        for (int p = 0; p < NR; p++) chk("reset_lane", lane(p), 32'h0);
        chk("reset_conflict", {31'b0, wr_conflict}, 32'h0);

        // mid-cycle reset clears lanes and storage immediately
        wr(0, 5, 32'hDEADBEEF); tick();
        idle(); rd(0, 5); tick();
        chk("x5_before_reset", lane(0), 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        for (int p = 0; p < NR; p++) chk("async_reset_lane", lane(p), 32'h0);
        chk("async_reset_conflict", {31'b0, wr_conflict}, 32'h0);
        rst = 1'b0;
        tick();
        chk("x5_after_reset", lane(0), 32'h0);
        idle(); wr(0, 6, 32'h1); rst = 1'b1; tick();
        rst = 1'b0; idle(); rd(0, 6); tick();
        chk("write_during_reset", lane(0), 32'h0);

        // x0 never stores, forwards or collides
        idle(); wr(0, 0, 32'h12345678); wr(1, 0, 32'h9); rd(0, 0); tick();
        chk("x0_same_cycle", lane(0), 32'h0);
        idle(); rd(0, 0); tick();
        chk("x0_later", lane(0), 32'h0);
        chk("x0_no_conflict", {31'b0, wr_conflict}, 32'h0);

        // forwarding beats old array contents
        idle(); wr(0, 3, 32'h11); tick();
        idle(); wr(0, 3, 32'h22); rd(0, 3); rd(1, 3); tick();
        chk("fwd_lane0", lane(0), 32'h22);
        chk("fwd_lane1", lane(1), 32'h22);
        idle(); rd(2, 3); tick();
        chk("fwd_stored", lane(2), 32'h22);

        // stall hold keeps stale data
        idle(); wr(0, 7, 32'hA5); tick();
        idle(); rd(1, 7); tick();
        chk("stall_first", lane(1), 32'hA5);
        idle(); rs_num[1*AW +: AW] = 4'd7; wr(1, 7, 32'h5A); tick();
        chk("stall_hold", lane(1), 32'hA5);
        idle(); tick();
        chk("stall_hold2", lane(1), 32'hA5);
        idle(); rd(1, 7); tick();
        chk("stall_release", lane(1), 32'h5A);

        // write priority and one-cycle conflict pulse
        idle(); wr(0, 9, 32'hAAAA); wr(1, 9, 32'hBBBB); rd(2, 9); tick();
        chk("prio_fwd", lane(2), 32'hBBBB);
        chk("conflict_pulse", {31'b0, wr_conflict}, 32'h1);
        idle(); rd(0, 9); tick();
        chk("prio_stored", lane(0), 32'hBBBB);
        chk("conflict_clear", {31'b0, wr_conflict}, 32'h0);
        idle(); wr(0, 10, 32'h1); wr(1, 11, 32'h2); rd(3, 10); tick();
        chk("distinct_no_conflict", {31'b0, wr_conflict}, 32'h0);
        chk("distinct_fwd", lane(3), 32'h1);

        // random traffic against the model
        for (int c = 0; c < 10000; c++) begin
            idle();
            ren = NR'($urandom);
            for (int p = 0; p < NR; p++) rs_num[p*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            reg_write = NW'($urandom);
            for (int j = 0; j < NW; j++) begin
                rd_num[j*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                rd_val[j*XLEN +: XLEN] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) rd_num[1*AW +: AW] = rd_num[0 +: AW];
            if ($urandom_range(0, 3) == 0) rs_num[0 +: AW] = rd_num[0 +: AW];
            tick();
        end
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
